// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if: command, RAM read port and output stream bundle for ram_burst_reader
//   master: the reader (drives rd_enb/rd_addr, out_data/out_valid/out_last, busy, done[, csum])
//   slave : the environment (drives start/start_addr/burst_len, rd_data, out_ready)
//   csum exists only when BURST_CHECKSUM_EN is defined
interface ram_burst_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   burst_len;
    logic              rd_enb;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef BURST_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif
    modport master (
        input  start, start_addr, burst_len, rd_data, out_ready,
`ifdef BURST_CHECKSUM_EN
        output csum,
`endif
        output rd_enb, rd_addr, out_data, out_valid, out_last, busy, done
    );
    modport slave (
        output start, start_addr, burst_len, rd_data, out_ready,
`ifdef BURST_CHECKSUM_EN
        input  csum,
`endif
        input  rd_enb, rd_addr, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: burst read sequencer for a 1-cycle-latency RAM with a 2-entry output buffer
//   clock, rst : single clock, synchronous active-high reset
//   bus        : ram_burst_reader_if.master (command, RAM read port, valid/ready stream, busy/done)
//   Optional BURST_CHECKSUM_EN adds bus.csum, the mod-2**DATA_W sum of the burst's beats.
module ram_burst_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic              clock,
    input logic              rst,
    ram_burst_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len_q, issued, beats;
    logic              inflight;
    logic [DATA_W-1:0] fifo [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic [2:0]        occ;
    logic              issue, push, pop, accept;
    assign push   = inflight;
    assign pop    = bus.out_valid && bus.out_ready;
    assign accept = (state == IDLE) && bus.start;
    // Credit the beat leaving this cycle so a full pipeline still sustains one read per cycle.
    assign occ    = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        case (state)
            IDLE:    if (bus.start) state_n = (bus.burst_len == '0) ? DONE : READ;
            READ: begin
                issue = (issued != len_q) && (occ < 3'd2);
                if (issue && (issued + 1'b1 == len_q)) state_n = DRAIN;
            end
            DRAIN:   if (!inflight && (count == 2'd0 || (count == 2'd1 && pop))) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            len_q    <= '0;
            issued   <= '0;
            beats    <= '0;
            inflight <= 1'b0;
            fifo     <= '{default: '0};
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            state    <= state_n;
            inflight <= issue;
            if (accept) begin
                addr   <= bus.start_addr;
                len_q  <= bus.burst_len;
                issued <= '0;
                beats  <= '0;
            end
            if (issue) begin
                addr   <= addr + 1'b1;
                issued <= issued + 1'b1;
            end
            if (push) begin
                fifo[wr_ptr] <= bus.rd_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                beats  <= beats + 1'b1;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
    assign bus.rd_enb    = issue;
    assign bus.rd_addr   = addr;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = fifo[rd_ptr];
    assign bus.out_last  = bus.out_valid && (beats + 1'b1 == len_q);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
`ifdef BURST_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
    always_ff @(posedge clock) begin
        if (rst || accept) csum_q <= '0;
        else if (pop)      csum_q <= csum_q + bus.out_data;
    end
    assign bus.csum = csum_q;
`endif
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: directed scoreboard bench for ram_burst_reader with a 1-cycle RAM model
module tb_ram_burst_reader;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;
    ram_burst_reader_if #(.DATA_W(8), .ADDR_W(4)) bus ();
    ram_burst_reader #(.DATA_W(8), .ADDR_W(4)) dut (.clock(clock), .rst(rst), .bus(bus.master));
    logic [7:0] mem [16];
    always @(posedge clock) if (bus.rd_enb) bus.rd_data <= mem[bus.rd_addr];
    int         checks = 0;
    int         failures = 0;
    logic [8:0] exp_q [$];
    logic [3:0] addr_q [$];
    logic [7:0] exp_sum;
    int         occ = 0;
    int         beats = 0;
    bit         prev_stall = 0;
    bit         prev_lastx = 0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic       xfer;
    logic [8:0] e;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(negedge clock) begin
        if (rst) begin
            occ        = 0;
            prev_stall = 0;
            prev_lastx = 0;
        end else begin
            if (prev_lastx) check("done_after_last", bus.done, 1);
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, prev_data);
                check("stall_last", bus.out_last, prev_last);
            end
            xfer = bus.out_valid && bus.out_ready;
            if (bus.rd_enb) begin
                check("rd_addr_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) check("rd_addr", bus.rd_addr, addr_q.pop_front());
                check("occupancy", (occ + 1 - int'(xfer)) <= 2, 1);
            end
            if (xfer) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", bus.out_data, e[7:0]);
                    check("beat_last", bus.out_last, e[8]);
                end
                beats++;
            end
            occ        = occ + int'(bus.rd_enb) - int'(xfer);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            prev_lastx = xfer && bus.out_last;
        end
    end
    task automatic run_burst(input logic [3:0] a, input logic [4:0] l);
        exp_sum = 8'd0;
        for (int i = 0; i < int'(l); i++) begin
            logic [3:0] ad;
            ad = a + 4'(i);
            addr_q.push_back(ad);
            exp_q.push_back({i == int'(l) - 1, mem[ad]});
            exp_sum += mem[ad];
        end
        @(posedge clock); #1;
        bus.start      = 1'b1;
        bus.start_addr = a;
        bus.burst_len  = l;
        bus.out_ready  = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask
    task automatic wait_done(input bit tog, output int n);
        bit got;
        got = 0;
        n   = 0;
        while (!got && n < 300) begin
            if (tog) bus.out_ready = ~bus.out_ready;
            @(negedge clock);
            if (bus.done) got = 1;
            else begin
                n++;
                @(posedge clock); #1;
            end
        end
        check("done_seen", got, 1);
        check("queue_empty", exp_q.size(), 0);
`ifdef BURST_CHECKSUM_EN
        check("csum", bus.csum, exp_sum);
`endif
        @(posedge clock); #1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        @(posedge clock); #1;
    endtask
    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 8'(3 * i);
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.burst_len  = '0;
        bus.out_ready  = 1'b1;
        // reset state
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        check("rst_rd_enb", bus.rd_enb, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        @(posedge clock); #1;
        rst = 1'b0;
        // full 16-word burst, latency and back-to-back throughput
        run_burst(4'd0, 5'd16);
        @(negedge clock);
        check("lat_rd_enb", bus.rd_enb, 1);
        check("lat_busy", bus.busy, 1);
        check("lat_valid_n1", bus.out_valid, 0);
        @(posedge clock); #1; @(negedge clock);
        check("lat_valid_n2", bus.out_valid, 0);
        @(posedge clock); #1; @(negedge clock);
        check("lat_valid_n3", bus.out_valid, 1);
        @(posedge clock); #1;
        wait_done(1'b0, n);
        check("full_cycles", n, 15);
        // wrapping burst
        run_burst(4'd14, 5'd4);
        wait_done(1'b0, n);
        // backpressure
        run_burst(4'd0, 5'd16);
        wait_done(1'b1, n);
        // zero-length burst
        run_burst(4'd3, 5'd0);
        @(negedge clock);
        check("len0_done", bus.done, 1);
        check("len0_valid", bus.out_valid, 0);
        check("len0_rd_enb", bus.rd_enb, 0);
        @(posedge clock); #1; @(negedge clock);
        check("len0_done_clear", bus.done, 0);
        check("len0_busy_clear", bus.busy, 0);
        @(posedge clock); #1;
        // start during busy is ignored
        run_burst(4'd2, 5'd4);
        bus.start      = 1'b1;
        bus.start_addr = 4'd5;
        bus.burst_len  = 5'd3;
        @(posedge clock); #1;
        bus.start = 1'b0;
        wait_done(1'b0, n);
        // reset mid-burst, then a clean short burst
        beats = 0;
        run_burst(4'd0, 5'd16);
        n = 0;
        while (beats < 5 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("abort_reached", beats >= 5, 1);
        @(posedge clock); #1;
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        exp_q.delete();
        addr_q.delete();
        @(posedge clock); #1;
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("abort_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_rd_enb", bus.rd_enb, 0);
        run_burst(4'd8, 5'd2);
        wait_done(1'b0, n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
